seg_scan_decoder: RTL

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// Recovers digit values from a multiplexed active-low 7-segment scan bus.
// A digit is accepted after STABLE_CNT identical consecutive samples; oVALID marks a complete frame.
module seg_scan_decoder #(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic [6:0]          iSEG,
  input  logic [NDIG-1:0]     iDIG,
  output logic [4*NDIG-1:0]   oBCD,
  output logic [NDIG-1:0]     oERR,
  output logic                oVALID
);

  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned CNT_W = 5;
  // Run length saturates one above the commit point so a held sample never recommits
  localparam logic [CNT_W-1:0] HIT = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] SAT = CNT_W'(STABLE_CNT + 1);

  logic [CNT_W-1:0]  r_len;
  logic [IDX_W-1:0]  r_idx;
  logic [6:0]        r_seg;
  logic [NDIG-1:0]   r_mask;
  logic [4*NDIG-1:0] r_bcd;
  logic [NDIG-1:0]   r_err;
  logic              r_valid;

  logic [3:0]        w_nlow;
  logic [IDX_W-1:0]  w_idx;
  logic              w_valid;
  logic              w_same;
  logic [CNT_W-1:0]  w_len_next;
  logic              w_commit;
  logic [3:0]        w_dec;
  logic              w_bad;
  logic [NDIG-1:0]   w_mask_set;
  logic              w_frame;

  // Count low digit-select bits and remember which one is low
  always_comb begin
    w_nlow = 4'd0;
    w_idx  = '0;
    for (int k = 0; k < int'(NDIG); k++) begin
      if (!iDIG[k]) begin
        w_nlow = w_nlow + 4'd1;
        w_idx  = IDX_W'(k);
      end
    end
  end

  assign w_valid = (w_nlow == 4'd1);
  assign w_same  = (r_len != '0) && (w_idx == r_idx) && (iSEG == r_seg);

  always_comb begin
    w_len_next = '0;
    if (w_valid) begin
      if (w_same) w_len_next = (r_len == SAT) ? SAT : r_len + CNT_W'(1);
      else        w_len_next = CNT_W'(1);
    end
  end

  assign w_commit = w_valid && (w_len_next == HIT);

  always_comb begin
    w_dec = 4'hF;
    w_bad = 1'b0;
    case (iSEG)
      7'b1000000: w_dec = 4'd0;
      7'b1111001: w_dec = 4'd1;
      7'b0100100: w_dec = 4'd2;
      7'b0110000: w_dec = 4'd3;
      7'b0011001: w_dec = 4'd4;
      7'b0010010: w_dec = 4'd5;
      7'b0000010: w_dec = 4'd6;
      7'b1111000: w_dec = 4'd7;
      7'b0000000: w_dec = 4'd8;
      7'b0010000: w_dec = 4'd9;
      7'b1111111: w_dec = 4'hF;
      default:    w_bad = 1'b1;
    endcase
  end

  // With exactly one low select bit, ~iDIG is the one-hot mask of the sampled digit
  assign w_mask_set = r_mask | ~iDIG;
  assign w_frame    = w_commit && (&w_mask_set);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_len   <= '0;
      r_idx   <= '0;
      r_seg   <= '1;
      r_mask  <= '0;
      r_bcd   <= '1;
      r_err   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_len   <= w_len_next;
      r_valid <= w_frame;
      if (w_valid) begin
        r_idx <= w_idx;
        r_seg <= iSEG;
      end
      if (w_commit) begin
        r_mask <= w_frame ? '0 : w_mask_set;
        for (int k = 0; k < int'(NDIG); k++) begin
          if (w_idx == IDX_W'(k)) begin
            r_bcd[4*k +: 4] <= w_dec;
            r_err[k]        <= w_bad;
          end
        end
      end
    end
  end

  assign oBCD   = r_bcd;
  assign oERR   = r_err;
  assign oVALID = r_valid;

endmodule
